// File: rtl/note_synth_if.sv
// Sample-side bus of the note synthesizer: note request in, audio sample out.
// The master is the tone source or testbench; the slave is note_synth.
interface note_synth_if;
  logic        [15:0] note_in;
  logic               sample_req;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               active;

  modport master (
    output note_in,
    output sample_req,
    input  sample_out,
    input  sample_valid,
    input  active
  );

  modport slave (
    input  note_in,
    input  sample_req,
    output sample_out,
    output sample_valid,
    output active
  );
endinterface

// File: rtl/note_synth.sv
// Square-wave tone generator with a linear attack/sustain/release envelope.
// Stage 1 advances phase/envelope on each sample tick; stage 2 forms the scaled sample.
module note_synth #(
  parameter int                 FS           = 48000,
  parameter logic signed [15:0] AMP          = 16'sd12000,
  parameter logic        [7:0]  ATTACK_STEP  = 8'd4,
  parameter logic        [7:0]  RELEASE_STEP = 8'd2
) (
  input  logic        clk,
  input  logic        reset,
  note_synth_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t             state_reg;
  logic        [15:0] phase_reg;
  logic        [15:0] inc_reg;
  logic        [7:0]  env_reg;
  logic               active_reg;
  logic               tick_reg;
  logic signed [15:0] sample_reg;
  logic               valid_reg;

  logic               note_ok;
  logic        [15:0] inc;
  logic        [15:0] base_phase;
  logic        [16:0] sum;
  logic        [15:0] phase_next;
  logic        [8:0]  env_up_sum;
  logic               env_full;
  logic        [7:0]  env_up;
  logic               rel_done;
  logic signed [15:0] wave;
  logic signed [23:0] wave_ext;
  logic signed [23:0] env_ext;
  logic signed [23:0] product;

  always_comb begin
    note_ok    = (bus.note_in != 16'd0) && (bus.note_in < 16'(FS / 2));
    inc        = note_ok ? bus.note_in : inc_reg;
    // A note starting from IDLE always begins from phase 0.
    base_phase = (state_reg == IDLE) ? 16'd0 : phase_reg;
    sum        = {1'b0, base_phase} + {1'b0, inc};
    phase_next = (sum >= 17'(FS)) ? 16'(sum - 17'(FS)) : sum[15:0];
    env_up_sum = {1'b0, env_reg} + {1'b0, ATTACK_STEP};
    env_full   = (env_up_sum >= 9'd255);
    env_up     = env_full ? 8'd255 : env_up_sum[7:0];
    rel_done   = (env_reg <= RELEASE_STEP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      phase_reg  <= 16'd0;
      inc_reg    <= 16'd0;
      env_reg    <= 8'd0;
      active_reg <= 1'b0;
      tick_reg   <= 1'b0;
    end else begin
      tick_reg <= bus.sample_req;
      if (bus.sample_req) begin
        phase_reg <= phase_next;
        if (note_ok)
          inc_reg <= bus.note_in;
        case (state_reg)
          IDLE: begin
            if (note_ok) begin
              state_reg  <= ATTACK;
              env_reg    <= env_up;
              active_reg <= 1'b1;
            end else begin
              phase_reg  <= 16'd0;
              inc_reg    <= 16'd0;
              env_reg    <= 8'd0;
              active_reg <= 1'b0;
            end
          end
          ATTACK, SUSTAIN: begin
            if (!note_ok) begin
              if (rel_done) begin
                state_reg  <= IDLE;
                env_reg    <= 8'd0;
                active_reg <= 1'b0;
              end else begin
                state_reg <= RELEASE;
                env_reg   <= env_reg - RELEASE_STEP;
              end
            end else if (state_reg == SUSTAIN) begin
              env_reg <= 8'd255;
            end else begin
              env_reg <= env_up;
              if (env_full)
                state_reg <= SUSTAIN;
            end
          end
          RELEASE: begin
            if (note_ok) begin
              state_reg <= ATTACK;
              env_reg   <= env_up;
            end else if (rel_done) begin
              state_reg  <= IDLE;
              env_reg    <= 8'd0;
              active_reg <= 1'b0;
            end else begin
              env_reg <= env_reg - RELEASE_STEP;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Stage 2 scales the waveform by the envelope registered in stage 1.
  always_comb begin
    wave     = (phase_reg < 16'(FS / 2)) ? AMP : -AMP;
    wave_ext = {{8{wave[15]}}, wave};
    env_ext  = {16'd0, env_reg};
    product  = wave_ext * env_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_reg <= 16'sd0;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= tick_reg;
      if (tick_reg)
        sample_reg <= product[23:8];
    end
  end

  assign bus.sample_out   = sample_reg;
  assign bus.sample_valid = valid_reg;
  assign bus.active       = active_reg;

endmodule
